// File: rtl/mcl_sine_special_bypass.sv
// Purpose : in-order sine wrapper; special x (NaN/Inf/out-of-range/tiny) bypass the MCL pipeline.
// Latency : bypass results 1 cycle minimum (no fall-through), normal results = pipeline latency.
// Backpressure: input stalls when the order FIFO is full or the pipeline refuses a normal x;
//               pipeline results are held off until their entry reaches the FIFO head.
// Ports   : clk/rst (sync, active-high); in_* input x stream; mcl_x_* to pipeline;
//           mcl_res_* from pipeline; out_* ordered results; ord_count FIFO fill;
//           range_err registered pulse for an accepted out-of-range x.
module mcl_sine_special_bypass #(
    parameter int FLT_EXP   = 11,
    parameter int FLT_FRAC  = 52,
    parameter int ORD_DEPTH = 32,
    parameter int TINY_EXP  = 997,
    parameter logic [FLT_EXP+FLT_FRAC:0] PI_HALF = 64'h3FF921FB54442D18,
    localparam int W  = FLT_EXP + FLT_FRAC + 1,
    localparam int AW = $clog2(ORD_DEPTH),
    localparam int CW = $clog2(ORD_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_avail,
    output logic          in_get,
    input  logic [W-1:0]  in_data,
    output logic          mcl_x_avail,
    input  logic          mcl_x_get,
    output logic [W-1:0]  mcl_x_data,
    input  logic          mcl_res_avail,
    output logic          mcl_res_get,
    input  logic [W-1:0]  mcl_res_data,
    output logic          out_avail,
    input  logic          out_get,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] ord_count,
    output logic          range_err
);

    localparam logic [FLT_EXP-1:0] TINY_E = FLT_EXP'(TINY_EXP);
    localparam logic [W-1:0] QNAN = {1'b0, {FLT_EXP{1'b1}}, 1'b1, {(FLT_FRAC-1){1'b0}}};
    localparam logic [W-1:0] FRAC_MSB = W'(1) << (FLT_FRAC - 1);

    // Classification of the offered x
    logic [FLT_EXP-1:0]  x_exp;
    logic [FLT_FRAC-1:0] x_frac;
    logic [W-2:0]        x_mag;
    logic                exp_ones, is_nan, is_inf, is_oor, is_tiny, byp;
    logic [W-1:0]        byp_res;

    assign x_exp    = in_data[W-2 -: FLT_EXP];
    assign x_frac   = in_data[FLT_FRAC-1:0];
    assign x_mag    = in_data[W-2:0];
    assign exp_ones = &x_exp;
    // Priority chain: NaN, Inf, out-of-range, tiny.
    assign is_nan   = exp_ones & (|x_frac);
    assign is_inf   = exp_ones & ~(|x_frac);
    assign is_oor   = ~exp_ones & (x_mag > PI_HALF[W-2:0]);
    assign is_tiny  = ~exp_ones & ~(x_mag > PI_HALF[W-2:0]) & (x_exp < TINY_E);
    assign byp      = is_nan | is_inf | is_oor | is_tiny;

    always_comb begin
        byp_res = in_data;
        if (is_nan) begin
            byp_res = in_data | FRAC_MSB;
        end else if (is_inf || is_oor) begin
            byp_res = QNAN;
        end
    end

    // Order FIFO state
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          range_err_q, range_err_d;
    logic          byp_mem_q [0:ORD_DEPTH-1];
    logic [W-1:0]  res_mem_q [0:ORD_DEPTH-1];

    logic full, empty, head_byp, push, pop;
    logic [W-1:0] head_res;

    assign full     = (cnt_q == CW'(ORD_DEPTH));
    assign empty    = (cnt_q == '0);
    assign head_byp = byp_mem_q[rd_ptr_q];
    assign head_res = res_mem_q[rd_ptr_q];

    // Input side: a normal x is accepted only together with the pipeline's get.
    assign mcl_x_data  = in_data;
    assign mcl_x_avail = in_avail & ~full & ~byp & ~rst;
    assign in_get      = in_avail & ~full & (byp | mcl_x_get) & ~rst;

    // Output side: a pipeline result is only consumed when its entry is the head.
    assign out_avail   = ~rst & ~empty & (head_byp | mcl_res_avail);
    assign out_data    = head_byp ? head_res : mcl_res_data;
    assign mcl_res_get = ~rst & ~empty & ~head_byp & out_get & mcl_res_avail;

    assign push = in_get;
    assign pop  = out_avail & out_get;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        range_err_d = push & is_oor;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            range_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            range_err_q <= range_err_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            byp_mem_q[wr_ptr_q] <= byp;
            res_mem_q[wr_ptr_q] <= byp_res;
        end
    end

    assign ord_count = cnt_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_mcl_sine_special_bypass.sv
module tb_mcl_sine_special_bypass;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_avail = 1'b0;
    logic        in_get;
    logic [63:0] in_data = '0;
    logic        mcl_x_avail;
    logic        mcl_x_get;
    logic [63:0] mcl_x_data;
    logic        mcl_res_avail;
    logic        mcl_res_get;
    logic [63:0] mcl_res_data;
    logic        out_avail;
    logic        out_get = 1'b0;
    logic [63:0] out_data;
    logic [5:0]  ord_count;
    logic        range_err;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] QNAN = 64'h7FF8000000000000;
    localparam logic [63:0] PIH  = 64'h3FF921FB54442D18;

    always #5 clk = ~clk;

    mcl_sine_special_bypass dut (
        .clk(clk), .rst(rst),
        .in_avail(in_avail), .in_get(in_get), .in_data(in_data),
        .mcl_x_avail(mcl_x_avail), .mcl_x_get(mcl_x_get), .mcl_x_data(mcl_x_data),
        .mcl_res_avail(mcl_res_avail), .mcl_res_get(mcl_res_get), .mcl_res_data(mcl_res_data),
        .out_avail(out_avail), .out_get(out_get), .out_data(out_data),
        .ord_count(ord_count), .range_err(range_err)
    );

    // Stand-in "sine": any distinguishable function of x will do.
    function automatic logic [63:0] fsin(input logic [63:0] x);
        return x ^ 64'h000000005A5A5A5A;
    endfunction

    // Model pipeline: fixed latency, optional random x_get stalls.
    typedef struct { logic [63:0] x; int t; } pe_t;
    pe_t pq[$];
    int  cyc = 0;
    int  lat = 20;
    bit  stall_en = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pq.delete();
        end else begin
            if (mcl_res_get && pq.size() > 0) pq.pop_front();
            if (mcl_x_avail && mcl_x_get) pq.push_back('{mcl_x_data, cyc});
        end
        mcl_x_get <= stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (pq.size() > 0 && (cyc - pq[0].t) >= lat) begin
            mcl_res_avail <= 1'b1;
            mcl_res_data  <= fsin(pq[0].x);
        end else begin
            mcl_res_avail <= 1'b0;
            mcl_res_data  <= '0;
        end
    end

    function automatic logic [63:0] exp_of(input logic [63:0] x);
        if (x[62:52] == 11'h7FF) return (x[51:0] != 0) ? (x | 64'h0008000000000000) : QNAN;
        if (x[62:0] > 63'h3FF921FB54442D18) return QNAN;
        if (x[62:52] < 11'd997) return x;
        return fsin(x);
    endfunction

    function automatic logic [63:0] gen_x();
        logic        s;
        logic [10:0] e;
        logic [51:0] f;
        s = 1'($urandom_range(0, 1));
        f = 52'({$urandom, $urandom});
        case ($urandom_range(0, 5))
            0: begin e = 11'd0; f = '0; end
            1: e = 11'($urandom_range(0, 996));
            2: e = 11'($urandom_range(997, 1022));
            3: begin e = 11'h7FF; f = f | 52'd1; end
            4: begin e = 11'h7FF; f = '0; end
            default: e = 11'($urandom_range(1024, 2046));
        endcase
        return {s, e, f};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_avail = 1'b1;
            in_data  = 64'd0;
            #1;
            n_tests++;
            if (in_get !== 1'b0) begin n_fail++; $display("FAIL reset_in_get cyc%0d got %b want 0", i, in_get); end
            n_tests++;
            if (out_avail !== 1'b0) begin n_fail++; $display("FAIL reset_out_avail cyc%0d got %b want 0", i, out_avail); end
            n_tests++;
            if (ord_count !== 6'd0) begin n_fail++; $display("FAIL reset_ord_count cyc%0d got %0d want 0", i, ord_count); end
        end
        @(negedge clk);
        rst = 1'b0;
        in_avail = 1'b0;
    endtask

    task automatic test_specials();
        logic [63:0] v [0:3];
        logic [63:0] e [0:3];
        int pulses = 0;
        v = '{64'h0, 64'h7FF0000000000000, 64'h7FF0000000000001, 64'h4000000000000000};
        e = '{64'h0, QNAN, 64'h7FF8000000000001, QNAN};
        out_get = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_avail = 1'b1;
            in_data  = v[i];
            #1;
            if (range_err === 1'b1) pulses++;
            n_tests++;
            if (in_get !== 1'b1 || mcl_x_avail !== 1'b0) begin
                n_fail++; $display("FAIL special_accept %0d in_get=%b mcl_x_avail=%b want 1/0", i, in_get, mcl_x_avail);
            end
        end
        @(negedge clk);
        in_avail = 1'b0;
        #1;
        if (range_err === 1'b1) pulses++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            out_get = 1'b1;
            #1;
            if (range_err === 1'b1) pulses++;
            n_tests++;
            if (out_avail !== 1'b1 || out_data !== e[i]) begin
                n_fail++; $display("FAIL special_out %0d avail=%b data=%h want 1/%h", i, out_avail, out_data, e[i]);
            end
        end
        @(negedge clk);
        out_get = 1'b0;
        #1;
        n_tests++;
        if (pulses != 1) begin n_fail++; $display("FAIL special_range_err pulses=%0d want 1", pulses); end
        n_tests++;
        if (ord_count !== 6'd0) begin n_fail++; $display("FAIL special_drain ord_count=%0d want 0", ord_count); end
    endtask

    task automatic test_ordering();
        logic [63:0] v [0:2];
        logic [63:0] e [0:2];
        int k = 0;
        v = '{64'h3FE0000000000000, 64'h0, 64'h3FF0000000000000};
        e = '{fsin(64'h3FE0000000000000), 64'h0, fsin(64'h3FF0000000000000)};
        lat = 20;
        out_get = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_avail = 1'b1;
            in_data  = v[i];
            #1;
            n_tests++;
            if (in_get !== 1'b1) begin n_fail++; $display("FAIL order_accept %0d in_get=%b want 1", i, in_get); end
        end
        for (int c = 0; c < 100 && k < 3; c++) begin
            @(negedge clk);
            in_avail = 1'b0;
            #1;
            if (c == 5) begin
                n_tests++;
                if (out_avail !== 1'b0 || ord_count !== 6'd3) begin
                    n_fail++; $display("FAIL order_hold out_avail=%b ord_count=%0d want 0/3", out_avail, ord_count);
                end
            end
            if (out_avail === 1'b1) begin
                n_tests++;
                if (out_data !== e[k]) begin n_fail++; $display("FAIL order_out %0d got %h want %h", k, out_data, e[k]); end
                k++;
            end
        end
        n_tests++;
        if (k != 3) begin n_fail++; $display("FAIL order_timeout got %0d results want 3", k); end
        @(negedge clk);
        out_get = 1'b0;
    endtask

    task automatic test_full();
        out_get  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            in_avail = 1'b1;
            in_data  = 64'(i + 1);
            #1;
            n_tests++;
            if (in_get !== 1'b1) begin n_fail++; $display("FAIL full_fill %0d in_get=%b want 1", i, in_get); end
        end
        @(negedge clk);
        in_data = 64'd100;
        #1;
        n_tests++;
        if (in_get !== 1'b0 || ord_count !== 6'd32) begin
            n_fail++; $display("FAIL full_block in_get=%b ord_count=%0d want 0/32", in_get, ord_count);
        end
        @(negedge clk);
        out_get = 1'b1;
        #1;
        n_tests++;
        if (in_get !== 1'b0 || out_avail !== 1'b1 || out_data !== 64'd1) begin
            n_fail++; $display("FAIL full_pop_same in_get=%b out_avail=%b data=%h want 0/1/1", in_get, out_avail, out_data);
        end
        @(negedge clk);
        out_get = 1'b0;
        #1;
        n_tests++;
        if (in_get !== 1'b1 || ord_count !== 6'd31) begin
            n_fail++; $display("FAIL full_resume in_get=%b ord_count=%0d want 1/31", in_get, ord_count);
        end
        @(negedge clk);
        in_avail = 1'b0;
        #1;
        n_tests++;
        if (ord_count !== 6'd32) begin n_fail++; $display("FAIL full_refill ord_count=%0d want 32", ord_count); end
        for (int i = 0; i < 32; i++) begin
            logic [63:0] want;
            want = (i < 31) ? 64'(i + 2) : 64'd100;
            @(negedge clk);
            out_get = 1'b1;
            #1;
            n_tests++;
            if (out_avail !== 1'b1 || out_data !== want) begin
                n_fail++; $display("FAIL full_drain %0d avail=%b data=%h want 1/%h", i, out_avail, out_data, want);
            end
        end
        @(negedge clk);
        out_get = 1'b0;
    endtask

    task automatic test_mid_reset();
        out_get = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_avail = 1'b1;
            in_data  = 64'h0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (in_get !== 1'b0 || out_avail !== 1'b0) begin
            n_fail++; $display("FAIL midrst_gate in_get=%b out_avail=%b want 0/0", in_get, out_avail);
        end
        @(negedge clk);
        rst = 1'b0;
        in_avail = 1'b0;
        #1;
        n_tests++;
        if (ord_count !== 6'd0 || out_avail !== 1'b0) begin
            n_fail++; $display("FAIL midrst_clear ord_count=%0d out_avail=%b want 0/0", ord_count, out_avail);
        end
    endtask

    task automatic test_boundary();
        logic [63:0] v [0:3];
        logic [63:0] e [0:3];
        logic        xa [0:3];
        int k = 0;
        v  = '{PIH, PIH + 64'd1, 64'h3E40000000000000, 64'h3E50000000000000};
        e  = '{fsin(PIH), QNAN, 64'h3E40000000000000, fsin(64'h3E50000000000000)};
        xa = '{1'b1, 1'b0, 1'b0, 1'b1};
        lat = 3;
        out_get = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                in_avail = 1'b1;
                in_data  = v[i];
            end else begin
                in_avail = 1'b0;
            end
            #1;
            if (i > 0) begin
                n_tests++;
                if (range_err !== (i == 2)) begin
                    n_fail++; $display("FAIL bound_range_err after %0d got %b want %b", i - 1, range_err, (i == 2));
                end
            end
            if (i < 4) begin
                n_tests++;
                if (mcl_x_avail !== xa[i] || in_get !== 1'b1) begin
                    n_fail++; $display("FAIL bound_class %0d mcl_x_avail=%b in_get=%b want %b/1", i, mcl_x_avail, in_get, xa[i]);
                end
            end
        end
        for (int c = 0; c < 100 && k < 4; c++) begin
            @(negedge clk);
            out_get = 1'b1;
            #1;
            if (out_avail === 1'b1) begin
                n_tests++;
                if (out_data !== e[k]) begin n_fail++; $display("FAIL bound_out %0d got %h want %h", k, out_data, e[k]); end
                k++;
            end
        end
        n_tests++;
        if (k != 4) begin n_fail++; $display("FAIL bound_timeout got %0d results want 4", k); end
        @(negedge clk);
        out_get = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] sb[$];
        logic [63:0] x, want;
        int sent = 0;
        int recv = 0;
        lat = 5;
        stall_en = 1'b1;
        x = gen_x();
        for (int c = 0; c < 20000 && recv < 1000; c++) begin
            @(negedge clk);
            in_avail = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_data  = x;
            out_get  = 1'($urandom_range(0, 1));
            #1;
            if (in_get === 1'b1) begin
                sb.push_back(exp_of(x));
                sent++;
                x = gen_x();
            end
            if (out_avail === 1'b1 && out_get === 1'b1) begin
                want = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
                n_tests++;
                if (out_data !== want) begin n_fail++; $display("FAIL b2b_out %0d got %h want %h", recv, out_data, want); end
                recv++;
            end
        end
        n_tests++;
        if (recv != 1000 || sb.size() != 0) begin
            n_fail++; $display("FAIL b2b_count got %0d results (%0d pending) want 1000 (0)", recv, sb.size());
        end
        @(negedge clk);
        in_avail = 1'b0;
        out_get  = 1'b0;
        stall_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_specials();
        test_ordering();
        test_full();
        test_mid_reset();
        test_boundary();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
